phy_tx_serializer: RTL

PHY_TX_SERIALIZER -- requirements
Module: phy_tx_serializer

---
 rtl/phy_types_pkg.sv | 28 ++
 rtl/tx_hold_buf.sv | 28 ++
 rtl/phy_tx_serializer.sv | 113 +++++++++++
 3 files changed

// File: rtl/phy_types_pkg.sv
// rtl/phy_types_pkg.sv - shared PHY types, the lane idle symbol and the TX shift FSM state
package phy_types_pkg;

  typedef enum logic [1:0] {
    SELECT_COMMA_1_FLIT = 2'd0,
    SELECT_COMMA_2_FLIT = 2'd1,
    SELECT_COMMA_DATA   = 2'd2
  } comma_length_sel_t;

  // K28.5 with negative running disparity
  localparam logic [9:0] IDLE_SYMBOL = 10'b0011111010;

  localparam int FLIT_BITS = 50;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_t;

  function automatic logic [2:0] nsym_of(input comma_length_sel_t sel);
    case (sel)
      SELECT_COMMA_1_FLIT: nsym_of = 3'd1;
      SELECT_COMMA_2_FLIT: nsym_of = 3'd2;
      default:             nsym_of = 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/tx_hold_buf.sv
// rtl/tx_hold_buf.sv - one-entry hold buffer; a write in the same cycle as a read refills it
module tx_hold_buf #(
  parameter int W = 56
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic         full,
  output logic [W-1:0] rd_data
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      full    <= 1'b0;
      rd_data <= '0;
    end else begin
      if (wr) begin
        full    <= 1'b1;
        rd_data <= wr_data;
      end else if (rd) begin
        full    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/phy_tx_serializer.sv
// rtl/phy_tx_serializer.sv - flit-to-lane serializer with idle fill and a one-flit hold buffer
module phy_tx_serializer
  import phy_types_pkg::*;
#(
  parameter int LANE_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [49:0]           flit_in,
  input  comma_length_sel_t     comma_length_sel,
  output logic [LANE_WIDTH-1:0] ser_out,
  output logic                  ser_valid,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BPS = 10 / LANE_WIDTH;
  localparam int CW  = 6;
  localparam int BW  = CW + FLIT_BITS;

  typedef logic [CW-1:0] cnt_t;

  tx_state_t              state_q, state_d;
  cnt_t                   cnt_q, cnt_d;
  cnt_t                   len_q, len_d;
  logic [FLIT_BITS-1:0]   sh_q, sh_d;
  logic [FLIT_BITS-1:0]   src;
  logic [LANE_WIDTH-1:0]  ser_out_d;
  logic                   ovf_q;

  logic                   buf_full;
  logic                   buf_rd;
  logic                   buf_wr;
  logic [BW-1:0]          buf_rd_data;
  logic                   take_direct;
  logic                   load;
  logic                   drop;
  cnt_t                   in_len;

  assign in_len = cnt_t'(nsym_of(comma_length_sel)) * cnt_t'(BPS);

  // len_q resets to 1 so the first edge after reset is a load point and idle fill starts on a symbol boundary
  assign load = (cnt_q == len_q - cnt_t'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + cnt_t'(1);
    len_d       = len_q;
    src         = sh_q;
    buf_rd      = 1'b0;
    take_direct = 1'b0;
    if (load) begin
      cnt_d = '0;
      if (buf_full) begin
        src     = buf_rd_data[FLIT_BITS-1:0];
        len_d   = buf_rd_data[BW-1:FLIT_BITS];
        state_d = ST_SHIFT;
        buf_rd  = 1'b1;
      end else if (start) begin
        src         = flit_in;
        len_d       = in_len;
        state_d     = ST_SHIFT;
        take_direct = 1'b1;
      end else begin
        src     = {IDLE_SYMBOL, {(FLIT_BITS-10){1'b0}}};
        len_d   = cnt_t'(BPS);
        state_d = ST_IDLE;
      end
    end
    ser_out_d = src[FLIT_BITS-1 -: LANE_WIDTH];
    sh_d      = src << LANE_WIDTH;
  end

  assign buf_wr = start && !take_direct && (!buf_full || buf_rd);
  assign drop   = start && !take_direct && buf_full && !buf_rd;

  tx_hold_buf #(
    .W(BW)
  ) u_hold (
    .CLK     (CLK),
    .nRST    (nRST),
    .wr      (buf_wr),
    .wr_data ({in_len, flit_in}),
    .rd      (buf_rd),
    .full    (buf_full),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= cnt_t'(1);
      sh_q      <= '0;
      ser_out   <= '0;
      ser_valid <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sh_q      <= sh_d;
      ser_out   <= ser_out_d;
      ser_valid <= (state_d == ST_SHIFT);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign busy     = (state_q == ST_SHIFT) || buf_full;
  assign overflow = ovf_q;

endmodule
